// File: rtl/gb_probe_capture.sv
// gb_probe_capture: trigger-armed {instruction, probe} sampler feeding a ready/valid FIFO
module gb_probe_capture #(
  parameter int INSTR_W = 8,
  parameter int PROBE_W = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [INSTR_W-1:0]         trigger,
  input  logic [CNT_W-1:0]           capture_len,
  input  logic [INSTR_W-1:0]         instruction,
  input  logic                       valid,
  input  logic [PROBE_W-1:0]         probe,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W+PROBE_W-1:0] out_data,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           captured,
  output logic [CNT_W-1:0]           dropped,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = INSTR_W + PROBE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t cur, nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, take, push, drop, rearm;
  logic [CNT_W-1:0] cap_inc, drop_inc;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && out_ready;
  assign rearm    = (cur == IDLE || cur == DONE) && arm;
  assign take     = valid && (cur == CAPTURE || (cur == ARMED && instruction == trigger));
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push     = take && !clear && (!full || pop);
  assign drop     = take && !clear && full && !pop;
  assign cap_inc  = captured == CNT_MAX ? captured : captured + CNT_W'(1);
  assign drop_inc = dropped == CNT_MAX ? dropped : dropped + CNT_W'(1);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign state     = cur;
  always_comb begin
    nxt = cur;
    if (clear) nxt = IDLE;
    else if (rearm) nxt = ARMED;
    else if (take) nxt = (capture_len != '0 && cap_inc == capture_len) ? DONE : CAPTURE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cur      <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      captured <= '0;
      dropped  <= '0;
      overflow <= 1'b0;
    end else begin
      cur <= nxt;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        captured <= '0;
        dropped  <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (rearm) captured <= '0;
        else if (take) captured <= cap_inc;
        if (drop) begin
          dropped  <= drop_inc;
          overflow <= 1'b1;
        end
      end
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr[AW-1:0]] <= {instruction, probe};
endmodule

// File: tb/tb_gb_probe_capture.sv
// tb_gb_probe_capture: randomized scoreboard bench for gb_probe_capture
module tb_gb_probe_capture;
  localparam int DEPTH = 16;
  logic clock = 1'b0;
  logic reset, arm, clear, valid, out_ready, out_valid, overflow;
  logic [7:0] trigger, instruction, probe;
  logic [15:0] capture_len, captured, dropped, out_data;
  logic [1:0] state;
  int vecs = 0, errs = 0;
  logic [15:0] sb[$];
  int mode = 0, occ = 0;
  logic [15:0] cap = 0, drp = 0;
  bit ovf = 0;

  gb_probe_capture #(.INSTR_W(8), .PROBE_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .arm(arm), .clear(clear), .trigger(trigger),
    .capture_len(capture_len), .instruction(instruction), .valid(valid), .probe(probe),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .state(state),
    .captured(captured), .dropped(dropped), .overflow(overflow));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL pop_unexpected: got %0h expected no data at %0t", out_data, $time);
      end else chk("pop_data", out_data, sb.pop_front());
    end

  // drive one cycle of inputs, advance the reference model, then check the DUT
  task automatic step(input bit a, input bit c, input bit v, input bit r,
                      input logic [7:0] ins, input logic [7:0] pr);
    bit pop_m, acc;
    arm = a; clear = c; valid = v; out_ready = r; instruction = ins; probe = pr;
    pop_m = occ > 0 && r;
    acc = 0;
    @(negedge clock); #1;
    if (c) begin
      mode = 0; occ = 0; cap = 0; drp = 0; ovf = 0;
      sb.delete();
    end else if ((mode == 0 || mode == 3) && a) begin
      mode = 1; cap = 0;
    end else if (v && (mode == 2 || (mode == 1 && ins == trigger))) begin
      if (occ < DEPTH || pop_m) begin
        sb.push_back({ins, pr});
        acc = 1;
      end else begin
        if (drp != 16'hFFFF) drp++;
        ovf = 1;
      end
      if (cap != 16'hFFFF) cap++;
      mode = (capture_len != 0 && cap == capture_len) ? 3 : 2;
    end
    if (!c) occ = occ + int'(acc) - int'(pop_m);
    @(posedge clock); #1;
    chk("state", state, mode);
    chk("captured", captured, cap);
    chk("dropped", dropped, drp);
    chk("overflow", overflow, ovf);
    chk("out_valid", out_valid, occ > 0);
    if (occ > 0 && sb.size() > 0) chk("head", out_data, sb[0]);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 0; arm = 0; clear = 0; valid = 0; out_ready = 0;
    trigger = 8'h3C; capture_len = 16'd4; instruction = 0; probe = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", state, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_captured", captured, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1;

    step(1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'h3A + 8'(i), 8'($urandom));
    chk("t2_state", state, 3);
    chk("t2_captured", captured, 4);
    drain(6);

    capture_len = 16'd20;
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 8'h3C, 8'($urandom));
    for (int i = 1; i < 20; i++) step(0, 0, 1, 0, 8'($urandom), 8'($urandom));
    chk("t3_dropped", dropped, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_captured", captured, 20);

    capture_len = 16'd10;
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 1, 8'h3C, 8'($urandom));
    for (int i = 1; i < 10; i++) step(0, 0, 1, 1, 8'($urandom), 8'($urandom));
    chk("t4_dropped", dropped, 4);
    chk("t4_out_valid", out_valid, 1);
    drain(DEPTH + 2);

    step(0, 1, 0, 1, 8'h00, 8'h00);
    capture_len = 16'd0;
    step(1, 0, 0, 1, 8'h00, 8'h00);
    step(0, 0, 1, 1, 8'h3C, 8'($urandom));
    for (int i = 1; i < 300; i++) step(0, 0, 1, 1, 8'($urandom), 8'($urandom));
    chk("t5_state", state, 2);
    chk("t5_captured", captured, 300);

    trigger = 8'h02;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) capture_len = 16'($urandom_range(0, 6));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, 1'($urandom),
           1'($urandom), 8'($urandom_range(0, 3)), 8'($urandom));
    end
    drain(DEPTH + 2);
    chk("rand_drained", sb.size(), 0);

    trigger = 8'h3C;
    step(0, 1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 8'h3C, 8'($urandom));
    for (int i = 1; i < 5; i++) step(0, 0, 1, 0, 8'($urandom), 8'($urandom));
    chk("t6_pre_captured", captured, 5);
    #2 reset = 0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_captured", captured, 0);
    chk("abort_dropped", dropped, 0);
    chk("abort_overflow", overflow, 0);
    mode = 0; occ = 0; cap = 0; drp = 0; ovf = 0;
    sb.delete();
    @(posedge clock); #1;
    reset = 1;
    step(1, 1, 0, 0, 8'h00, 8'h00);
    chk("clear_wins", state, 0);
    step(0, 0, 1, 0, 8'h3C, 8'h11);
    chk("idle_ignores", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
